// File: rtl/l8_tx_arbiter_pkg.sv
// Shared l8 stream widths, arbiter state encoding and pointer helper.
package l8_tx_arbiter_pkg;

    localparam int L8_DATA_W  = 64;
    localparam int L8_EMPTY_W = 3;
    localparam int MAX_IN     = 8;
    localparam int PTR_W      = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Round-robin pointer advance, wrapping at the number of active ports.
    function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] idx,
                                                      input int num);
        if (int'(idx) + 1 >= num) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/l8_tx_arbiter_if.sv
// Bundle of the NUM_IN requester streams and the single muxed stream to the MAC.
interface l8_tx_arbiter_if #(
    parameter int NUM_IN = 2
);
    import l8_tx_arbiter_pkg::*;

    logic [L8_DATA_W*NUM_IN-1:0]  in_data;
    logic [NUM_IN-1:0]            in_startofpacket;
    logic [NUM_IN-1:0]            in_endofpacket;
    logic [L8_EMPTY_W*NUM_IN-1:0] in_empty;
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN-1:0]            in_ready;

    logic [L8_DATA_W-1:0]         out_data;
    logic                         out_startofpacket;
    logic                         out_endofpacket;
    logic [L8_EMPTY_W-1:0]        out_empty;
    logic                         out_valid;
    logic                         out_ready;

    // Arbiter side
    modport slave (
        input  in_data, in_startofpacket, in_endofpacket, in_empty, in_valid,
        output in_ready,
        output out_data, out_startofpacket, out_endofpacket, out_empty, out_valid,
        input  out_ready
    );

    // Requester/MAC side
    modport master (
        output in_data, in_startofpacket, in_endofpacket, in_empty, in_valid,
        input  in_ready,
        input  out_data, out_startofpacket, out_endofpacket, out_empty, out_valid,
        output out_ready
    );

endinterface

// File: rtl/l8_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module l8_tx_arbiter_rr_pick
    import l8_tx_arbiter_pkg::*;
#(
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt
);

    logic [NUM_IN-1:0] masked;
    logic [NUM_IN-1:0] pick_src;
    logic              found;

    // Requests at or above ptr win first; otherwise wrap to the lowest request.
    always_comb begin
        masked   = '0;
        gnt      = '0;
        found    = 1'b0;
        for (int j = 0; j < NUM_IN; j++) begin
            masked[j] = req[j] && (PTR_W'(j) >= ptr);
        end
        pick_src = (|masked) ? masked : req;
        for (int j = 0; j < NUM_IN; j++) begin
            if (pick_src[j] && !found) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l8_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_IN l8 streams onto one MAC TX stream.
// Stray non-SOP beats seen while idle are swallowed and counted.
module l8_tx_arbiter
    import l8_tx_arbiter_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    l8_tx_arbiter_if.slave    bus,
    output logic [NUM_IN-1:0] grant,
    output logic [CNT_W-1:0]  drop_cnt
);

    // state   | meaning
    // ST_IDLE | no owner; drop stray beats, pick next SOP requester
    // ST_BUSY | grant_q owns the stream until its EOP beat is accepted

    arb_state_t             state_q, state_d;
    logic [NUM_IN-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_IN-1:0]      cand, stray, pick;
    logic [PTR_W-1:0]       owner_idx;
    logic                   acceptable, beat_acc;

    logic [L8_DATA_W-1:0]   sel_data;
    logic                   sel_sop, sel_eop, sel_valid;
    logic [L8_EMPTY_W-1:0]  sel_empty;

    logic [L8_DATA_W-1:0]   out_data_q;
    logic                   out_sop_q, out_eop_q, out_valid_q;
    logic [L8_EMPTY_W-1:0]  out_empty_q;
    logic [CNT_W-1:0]       drop_q;

    assign acceptable = ~out_valid_q | bus.out_ready;
    assign cand       = bus.in_valid & bus.in_startofpacket;
    assign stray      = bus.in_valid & ~bus.in_startofpacket;

    l8_tx_arbiter_rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_rr_pick (
        .req (cand),
        .ptr (rr_ptr_q),
        .gnt (pick)
    );

    always_comb begin
        sel_data  = '0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_valid = 1'b0;
        sel_empty = '0;
        owner_idx = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (grant_q[j]) begin
                sel_data  = bus.in_data[L8_DATA_W*j +: L8_DATA_W];
                sel_sop   = bus.in_startofpacket[j];
                sel_eop   = bus.in_endofpacket[j];
                sel_valid = bus.in_valid[j];
                sel_empty = bus.in_empty[L8_EMPTY_W*j +: L8_EMPTY_W];
                owner_idx = PTR_W'(j);
            end
        end
    end

    assign beat_acc = (state_q == ST_BUSY) & sel_valid & acceptable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        bus.in_ready = '0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = stray;
                if (|cand) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                end
            end
            ST_BUSY: begin
                bus.in_ready = grant_q & {NUM_IN{acceptable}};
                if (beat_acc && sel_eop) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = ptr_wrap_inc(owner_idx, NUM_IN);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        // Nothing may be consumed while reset is asserted.
        if (rst) begin
            bus.in_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_valid_q <= 1'b0;
        end else if (beat_acc) begin
            out_data_q  <= sel_data;
            out_sop_q   <= sel_sop;
            out_eop_q   <= sel_eop;
            out_empty_q <= sel_empty;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if ((state_q == ST_IDLE) && (|stray) && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign bus.out_data          = out_data_q;
    assign bus.out_startofpacket = out_sop_q;
    assign bus.out_endofpacket   = out_eop_q;
    assign bus.out_empty         = out_empty_q;
    assign bus.out_valid         = out_valid_q;
    assign grant                 = grant_q;
    assign drop_cnt              = drop_q;

endmodule

// File: tb/tb_l8_tx_arbiter.sv
// Randomized scoreboard bench for l8_tx_arbiter against a packet-level round-robin model.
module tb_l8_tx_arbiter;

    localparam int N = 2;

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  emp;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l8_tx_arbiter_if #(.NUM_IN(N)) io ();
    l8_tx_arbiter_if #(.NUM_IN(N)) io_s ();
    logic [N-1:0]  grant, grant_s;
    logic [15:0]   drop_cnt;
    logic [3:0]    drop_s;

    l8_tx_arbiter #(.NUM_IN(N), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (io.slave), .grant (grant), .drop_cnt (drop_cnt)
    );

    // Narrow counter instance used only to reach saturation quickly.
    l8_tx_arbiter #(.NUM_IN(N), .CNT_W(4)) dut_s (
        .clk (clk), .rst (rst), .bus (io_s.slave), .grant (grant_s), .drop_cnt (drop_s)
    );

    beat_t     pq[N][$];
    beat_t     expq[$];
    logic [N-1:0] pres = '0;
    logic      ordy = 1'b1;
    logic      rst_next = 1'b1;
    int        valid_pct = 100, rdy_pct = 100;
    bit        rdy_pat = 0;
    int        pat_i = 0;
    logic      pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int        seq = 0;
    int        errors = 0, checks = 0;
    int        out_acc_cnt = 0;

    // Reference model state
    bit        m_busy = 0;
    int        m_owner = 0, m_ptr = 0, m_drop = 0;
    bit        m_ovalid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add_pkt(input int p, input int nb, input logic [2:0] emp);
        beat_t x;
        for (int b = 0; b < nb; b++) begin
            x.d   = {8'(p), 8'(seq), 16'(b), $urandom()};
            x.sop = (b == 0);
            x.eop = (b == nb - 1);
            x.emp = x.eop ? emp : 3'($urandom_range(0, 7));
            pq[p].push_back(x);
        end
        seq++;
    endtask

    task automatic add_junk(input int p);
        beat_t x;
        x.d   = {8'hEE, 24'(seq), $urandom()};
        x.sop = 1'b0;
        x.eop = 1'b0;
        x.emp = 3'($urandom_range(0, 7));
        pq[p].push_back(x);
        seq++;
    endtask

    task automatic drive();
        rst          = rst_next;
        io.in_valid  = pres;
        io.out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            io.in_data[64*i +: 64]       = pres[i] ? pq[i][0].d : 64'd0;
            io.in_startofpacket[i]       = pres[i] ? pq[i][0].sop : 1'b0;
            io.in_endofpacket[i]         = pres[i] ? pq[i][0].eop : 1'b0;
            io.in_empty[3*i +: 3]        = pres[i] ? pq[i][0].emp : 3'd0;
        end
    endtask

    // One clock: check DUT against the model, advance model and drivers, then drive.
    task automatic cycle();
        logic [N-1:0] fire, exp_rdy, cand;
        int w;
        @(negedge clk);
        fire    = '0;
        exp_rdy = '0;
        cand    = '0;
        if (rst) begin
            chk("in_ready_rst", 64'(io.in_ready), 64'd0);
            if (m_busy) begin
                while (pq[m_owner].size() > 0 && !pq[m_owner][0].eop) void'(pq[m_owner].pop_front());
                if (pq[m_owner].size() > 0) void'(pq[m_owner].pop_front());
            end
            m_busy = 0; m_owner = 0; m_ptr = 0; m_drop = 0; m_ovalid = 0;
            expq.delete();
        end else begin
            chk("grant", 64'(grant), m_busy ? 64'(1 << m_owner) : 64'd0);
            chk("out_valid", 64'(io.out_valid), 64'(m_ovalid));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            for (int i = 0; i < N; i++) begin
                if (m_busy) exp_rdy[i] = (i == m_owner) && (!m_ovalid || io.out_ready);
                else        exp_rdy[i] = pres[i] && !pq[i][0].sop;
                cand[i] = pres[i] && pq[i][0].sop;
            end
            chk("in_ready", 64'(io.in_ready), 64'(exp_rdy));
            fire = pres & io.in_ready;
            if (!m_busy) begin
                if (|(pres & ~cand)) m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
                m_ovalid = m_ovalid && !io.out_ready;
                if (cand != '0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && cand[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    m_owner = w;
                    m_busy  = 1;
                    for (int b = 0; b < pq[w].size(); b++) begin
                        expq.push_back(pq[w][b]);
                        if (pq[w][b].eop) break;
                    end
                end
            end else begin
                if (fire[m_owner]) begin
                    m_ovalid = 1;
                    if (pq[m_owner][0].eop) begin
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % N;
                    end
                end else begin
                    m_ovalid = m_ovalid && !io.out_ready;
                end
            end
            for (int i = 0; i < N; i++) if (fire[i]) void'(pq[i].pop_front());
        end
        for (int i = 0; i < N; i++)
            pres[i] = (pq[i].size() > 0) && ($urandom_range(0, 99) < valid_pct);
        if (rdy_pat) begin
            ordy = pat[pat_i % 4];
            pat_i++;
        end else begin
            ordy = ($urandom_range(0, 99) < rdy_pct);
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) cycle();
    endtask

    task automatic rst_pulse(input int n);
        rst_next = 1'b1;
        run(n);
        rst_next = 1'b0;
        cycle();
    endtask

    task automatic drain(input string name, input int maxc);
        int t = 0;
        while (t < maxc && (pq[0].size() + pq[1].size() + expq.size() > 0 || io.out_valid)) begin
            cycle();
            t++;
        end
        chk(name, 64'(pq[0].size() + pq[1].size() + expq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && io.out_valid && io.out_ready) begin
            out_acc_cnt++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: actual data=%0h required=no beat at %0t", io.out_data, $time);
            end else begin
                e = expq.pop_front();
                chk("out_data", io.out_data, e.d);
                chk("out_ctl", 64'({io.out_startofpacket, io.out_endofpacket, io.out_empty}),
                    64'({e.sop, e.eop, e.emp}));
            end
        end
    end

    initial begin
        int snap;
        io_s.in_valid = 2'b10; io_s.in_startofpacket = '0; io_s.in_endofpacket = '0;
        io_s.in_data = '0; io_s.in_empty = '0; io_s.out_ready = 1'b1;
        drive();

        // 1: reset values, then a 4-beat packet with empty=3 on port 0
        rst_pulse(3);
        chk("rst_out_data", io.out_data, 64'd0);
        chk("rst_out_ctl", 64'({io.out_startofpacket, io.out_endofpacket, io.out_empty}), 64'd0);
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        add_pkt(0, 4, 3'd3);
        run(10);
        chk("sat_drop_10", 64'(drop_s), 64'd10);
        drain("t1_drain", 50);

        // 2: both ports, three 3-beat packets each, from reset
        rst_pulse(1);
        for (int k = 0; k < 3; k++) begin
            add_pkt(0, 3, 3'($urandom_range(0, 7)));
            add_pkt(1, 3, 3'($urandom_range(0, 7)));
        end
        drain("t2_drain", 200);

        // 3: out_ready toggling 1,0,0,1 while port 0 owns a long packet
        rdy_pat = 1;
        add_pkt(0, 6, 3'd5);
        add_pkt(1, 2, 3'd1);
        drain("t3_drain", 200);
        rdy_pat = 0;

        // 4: stray non-SOP beats while idle
        for (int k = 0; k < 5; k++) add_junk(1);
        run(8);
        chk("drop_5", 64'(drop_cnt), 64'd5);
        chk("sat_drop_15", 64'(drop_s), 64'd15);
        chk("sat_no_out", 64'({io_s.out_valid, grant_s}), 64'd0);

        // 5: back-to-back single-beat packets on port 0, then port 1 joins
        for (int k = 0; k < 14; k++) add_pkt(0, 1, 3'($urandom_range(0, 7)));
        run(6);
        snap = out_acc_cnt;
        run(20);
        chk("single_rate", 64'(out_acc_cnt - snap), 64'd10);
        add_pkt(1, 1, 3'd2);
        add_pkt(0, 1, 3'd4);
        drain("t5_drain", 100);

        // 6: reset in the middle of a 6-beat packet
        add_pkt(0, 6, 3'd0);
        for (int t = 0; t < 50 && pq[0].size() > 5; t++) cycle();
        chk("t6_reached_beat", 64'(pq[0].size() <= 5), 64'd1);
        rst_pulse(1);
        chk("t6_out_valid", 64'(io.out_valid), 64'd0);
        chk("t6_grant", 64'(grant), 64'd0);
        add_pkt(0, 3, 3'd6);
        drain("t6_drain", 100);

        // Random traffic with stray beats and random back-pressure
        valid_pct = 75;
        rdy_pct   = 70;
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 9) == 0) add_junk(p);
                add_pkt(p, $urandom_range(1, 8), 3'($urandom_range(0, 7)));
            end
        end
        drain("rand_drain", 6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
